// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions.
// State encoding and register-file constants used by hazard logic.
package pipe_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int unsigned MULDIV_CYCLES_DEF = 4;
  localparam int unsigned BUSY_CNT_W = 4;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator.
// Pure address compare between a load in EX and sources in ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic [4:0] ex_rt_i,
  input  logic       ex_memread_i,
  output logic       luh_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt_i == id_rs_i);
  assign rt_hit = id_uses_rt_i & (ex_rt_i == id_rt_i);

  assign luh_o = ex_memread_i & (ex_rt_i != REG_ZERO)
               & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall, flush and mult/div freeze.
// Also counts cycles with the PC held.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic             ex_muldiv_start,
  input  logic             branch_taken,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_wen,
  output logic             idex_flush,
  output logic             muldiv_busy,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [BUSY_CNT_W-1:0] BUSY_INIT =
    BUSY_CNT_W'(MULDIV_CYCLES - 2);

  hz_state_e             state_q, state_d;
  logic [BUSY_CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]      stall_q, stall_d;
  logic                  luh;

  hazard_detect u_detect (
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rt_i (id_uses_rt),
    .ex_rt_i      (ex_rt),
    .ex_memread_i (ex_memread),
    .luh_o        (luh)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    ifid_flush  = 1'b0;
    idex_wen    = 1'b1;
    idex_flush  = 1'b0;
    muldiv_busy = 1'b0;
    muldiv_done = 1'b0;
    if (reset) begin
      pc_wen     = 1'b0;
      ifid_wen   = 1'b0;
      idex_wen   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state_q == ST_BUSY) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_wen    = 1'b0;
      muldiv_busy = 1'b1;
      if (cnt_q == '0) begin
        muldiv_done = 1'b1;
        state_d     = ST_RUN;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_muldiv_start) begin
      pc_wen   = 1'b0;
      ifid_wen = 1'b0;
      idex_wen = 1'b0;
      state_d  = ST_BUSY;
      cnt_d    = BUSY_INIT;
    end else if (luh) begin
      // Hold IF/ID and bubble ID/EX; the load leaves EX next cycle.
      pc_wen     = 1'b0;
      ifid_wen   = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign stall_d = pc_wen ? stall_q : stall_q + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// Directed scenarios plus randomized traffic against a cycle model.
module tb_hazard_ctrl;

  localparam int MC = 4;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_memread;
  logic          ex_muldiv_start, branch_taken;
  logic          pc_wen, ifid_wen, ifid_flush;
  logic          idex_wen, idex_flush;
  logic          muldiv_busy, muldiv_done;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Model state: BUSY cycles still to come, and the stall total.
  int m_freeze = 0;
  int m_cnt    = 0;
  logic [6:0] exp_v;
  logic [6:0] obs_v;

  always #5 clock = ~clock;

  hazard_ctrl #(.MULDIV_CYCLES(MC), .CNT_W(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_rt           (ex_rt),
    .ex_memread      (ex_memread),
    .ex_muldiv_start (ex_muldiv_start),
    .branch_taken    (branch_taken),
    .pc_wen          (pc_wen),
    .ifid_wen        (ifid_wen),
    .ifid_flush      (ifid_flush),
    .idex_wen        (idex_wen),
    .idex_flush      (idex_flush),
    .muldiv_busy     (muldiv_busy),
    .muldiv_done     (muldiv_done),
    .stall_count     (stall_count)
  );

  assign obs_v = {pc_wen, ifid_wen, ifid_flush,
                  idex_wen, idex_flush,
                  muldiv_busy, muldiv_done};

  // Order: pc_wen ifid_wen ifid_flush idex_wen idex_flush busy done
  function automatic logic [6:0] model_out();
    logic hz;
    hz = ex_memread && ex_rt != 0 &&
         (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    if (reset)              return 7'b0010100;
    if (m_freeze > 0)       return {5'b00000, 1'b1, m_freeze == 1};
    if (branch_taken)       return 7'b1111100;
    if (ex_muldiv_start)    return 7'b0000000;
    if (hz)                 return 7'b1001100 & 7'b0001100;
    return 7'b1101000;
  endfunction

  always @(posedge clock) begin
    logic [6:0] o;
    o = model_out();
    if (reset) begin
      m_freeze = 0;
      m_cnt    = 0;
    end else begin
      if (!o[6]) m_cnt = (m_cnt + 1) % (1 << CW);
      if (m_freeze > 0) m_freeze = m_freeze - 1;
      else if (!branch_taken && ex_muldiv_start) m_freeze = MC - 1;
    end
  end

  task automatic drive(input logic r, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt,
                       input logic [4:0] ert, input logic mr,
                       input logic ms, input logic br);
    @(negedge clock);
    reset = r; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_rt = ert; ex_memread = mr;
    ex_muldiv_start = ms; branch_taken = br;
    #1;
    exp_v = model_out();
  endtask

  task automatic idle();
    drive(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_v !== 7'b0010100) begin
      errors++;
      $display("FAIL reset_outs: got %b want %b", obs_v, 7'b0010100);
    end
    idle();
    checks++;
    if (obs_v !== 7'b1101000 || stall_count !== 0) begin
      errors++;
      $display("FAIL reset_run: got %b/%0d want 1101000/0",
               obs_v, stall_count);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 5'd5, 5'd9, 0, 5'd5, 1, 0, 0);
    checks++;
    if (obs_v !== 7'b0001100) begin
      errors++;
      $display("FAIL luh_rs: got %b want 0001100", obs_v);
    end
    idle();
    checks++;
    if (obs_v !== 7'b1101000 || stall_count !== 1) begin
      errors++;
      $display("FAIL luh_after: got %b/%0d want 1101000/1",
               obs_v, stall_count);
    end
    drive(0, 5'd4, 5'd6, 1, 5'd6, 1, 0, 0);
    checks++;
    if (obs_v !== 7'b0001100) begin
      errors++;
      $display("FAIL luh_rt: got %b want 0001100", obs_v);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    drive(0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0);
    checks++;
    if (obs_v !== 7'b1101000) begin
      errors++;
      $display("FAIL nohz_zero: got %b want 1101000", obs_v);
    end
    drive(0, 5'd3, 5'd7, 0, 5'd7, 1, 0, 0);
    checks++;
    if (obs_v !== 7'b1101000) begin
      errors++;
      $display("FAIL nohz_rt_unused: got %b want 1101000", obs_v);
    end
    idle();
    checks++;
    if (stall_count !== 0) begin
      errors++;
      $display("FAIL nohz_cnt: got %0d want 0", stall_count);
    end
  endtask

  task automatic test_muldiv();
    logic [6:0] want [MC];
    want[0] = 7'b0000000;
    want[1] = 7'b0000010;
    want[2] = 7'b0000010;
    want[3] = 7'b0000011;
    do_reset();
    for (int i = 0; i < MC; i++) begin
      drive(0, 5'd5, 5'd5, 1, 5'd5, i == 0, i == 0, i == 2);
      checks++;
      if (obs_v !== want[i]) begin
        errors++;
        $display("FAIL muldiv_c%0d: got %b want %b", i, obs_v, want[i]);
      end
    end
    idle();
    checks++;
    if (obs_v !== 7'b1101000 || stall_count !== MC) begin
      errors++;
      $display("FAIL muldiv_end: got %b/%0d want 1101000/%0d",
               obs_v, stall_count, MC);
    end
  endtask

  task automatic test_branch_vs_luh();
    do_reset();
    drive(0, 5'd8, 5'd0, 0, 5'd8, 1, 1, 1);
    checks++;
    if (obs_v !== 7'b1111100) begin
      errors++;
      $display("FAIL br_luh: got %b want 1111100", obs_v);
    end
    idle();
    checks++;
    if (obs_v !== 7'b1101000 || stall_count !== 0) begin
      errors++;
      $display("FAIL br_after: got %b/%0d want 1101000/0",
               obs_v, stall_count);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_v !== 7'b0010100) begin
      errors++;
      $display("FAIL rst_busy_outs: got %b want 0010100", obs_v);
    end
    idle();
    checks++;
    if (obs_v !== 7'b1101000 || stall_count !== 0) begin
      errors++;
      $display("FAIL rst_busy_after: got %b/%0d want 1101000/0",
               obs_v, stall_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++)
      drive(0, 5'd2, 5'd0, 0, 5'd2, 1, 0, 0);
    idle();
    checks++;
    if (stall_count !== 1) begin
      errors++;
      $display("FAIL wrap: got %0d want 1", stall_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 5) == 0);
      checks++;
      if (obs_v !== exp_v || stall_count !== CW'(m_cnt)) begin
        errors++;
        $display("FAIL rand_%0d: got %b/%0d want %b/%0d",
                 i, obs_v, stall_count, exp_v, m_cnt);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rt = 0;
    ex_memread = 0; ex_muldiv_start = 0; branch_taken = 0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_muldiv();
    test_branch_vs_luh();
    test_reset_mid_busy();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
